// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if: requester and Memory data-port bundle for the arbiter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE_W = 3
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic [MODE_W-1:0] wmode0;
  logic [MODE_W-1:0] rmode0;
  logic              unsigned0;
  logic              lock0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [MODE_W-1:0] wmode1;
  logic [MODE_W-1:0] rmode1;
  logic              unsigned1;
  logic              lock1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [MODE_W-1:0] mem_writeMode;
  logic [MODE_W-1:0] mem_readMode;
  logic              mem_unsignedLoad;
  logic [DATA_W-1:0] mem_dataOutput;

  modport slave (
    input  req0, addr0, wdata0, wmode0, rmode0, unsigned0, lock0,
    input  req1, addr1, wdata1, wmode1, rmode1, unsigned1, lock1,
    input  mem_dataOutput,
    output ack0, rdata0, ack1, rdata1,
    output mem_address, mem_data, mem_writeMode, mem_readMode, mem_unsignedLoad
  );

  modport master (
    output req0, addr0, wdata0, wmode0, rmode0, unsigned0, lock0,
    output req1, addr1, wdata1, wmode1, rmode1, unsigned1, lock1,
    output mem_dataOutput,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_address, mem_data, mem_writeMode, mem_readMode, mem_unsignedLoad
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: two-requester arbiter for the Memory data port           |
// | Option: MEM_ARB_ROUND_ROBIN_EN selects round-robin ties (else fixed prio)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE_W = 3
) (
  input  wire               clk,
  input  wire               rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // ReadWriteMode_NONE is the all-zero code
  localparam logic [MODE_W-1:0] MODE_NONE = '0;

  state_t            state;
  state_t            state_next;
  logic [1:0]        req;
  logic              any_req;
  logic              winner;
  logic              tie_winner;
  logic              lock_held;
  logic              lock_owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [MODE_W-1:0] lat_wmode;
  logic [MODE_W-1:0] lat_rmode;
  logic              lat_unsigned;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              rr_ptr;
`endif

  assign req     = {bus.req1, bus.req0};
  assign any_req = |req;

  always_comb begin
    tie_winner = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_winner = ~rr_ptr;
`endif
    winner = 1'b0;
    if (lock_held && req[lock_owner]) begin
      winner = lock_owner;
    end else if (req == 2'b11) begin
      winner = tie_winner;
    end else begin
      winner = req[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    busy              = 1'b1;
    bus.ack0          = 1'b0;
    bus.ack1          = 1'b0;
    bus.mem_writeMode = MODE_NONE;
    bus.mem_readMode  = MODE_NONE;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        bus.mem_writeMode = lat_wmode;
        bus.mem_readMode  = lat_rmode;
        state_next        = CAPTURE;
      end
      CAPTURE: state_next = DONE;
      DONE: begin
        bus.ack0   = ~grant_id;
        bus.ack1   = grant_id;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the fields present at grant are used; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_wmode    <= MODE_NONE;
      lat_rmode    <= MODE_NONE;
      lat_unsigned <= 1'b0;
      grant_id     <= 1'b0;
      lock_held    <= 1'b0;
      lock_owner   <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr       <= 1'b1;
`endif
    end else begin
      if (state == IDLE) begin
        if (any_req) begin
          grant_id   <= winner;
          lock_owner <= winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_ptr     <= winner;
`endif
          if (winner) begin
            lat_addr     <= bus.addr1;
            lat_wdata    <= bus.wdata1;
            lat_wmode    <= bus.wmode1;
            lat_rmode    <= bus.rmode1;
            lat_unsigned <= bus.unsigned1;
            lock_held    <= bus.lock1;
          end else begin
            lat_addr     <= bus.addr0;
            lat_wdata    <= bus.wdata0;
            lat_wmode    <= bus.wmode0;
            lat_rmode    <= bus.rmode0;
            lat_unsigned <= bus.unsigned0;
            lock_held    <= bus.lock0;
          end
        end else begin
          lock_held <= 1'b0;
        end
      end
      if (state == CAPTURE && lat_rmode != MODE_NONE) begin
        if (grant_id) begin
          rdata1 <= bus.mem_dataOutput;
        end else begin
          rdata0 <= bus.mem_dataOutput;
        end
      end
    end
  end

  assign bus.mem_address      = lat_addr;
  assign bus.mem_data         = lat_wdata;
  assign bus.mem_unsignedLoad = lat_unsigned;
  assign bus.rdata0           = rdata0;
  assign bus.rdata1           = rdata1;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed bench with a little-endian Memory model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam logic [2:0] M_NONE  = 3'd0;
  localparam logic [2:0] M_WORD  = 3'd1;
  localparam logic [2:0] M_HALF  = 3'd2;
  localparam logic [2:0] M_BYTE  = 3'd3;
  localparam logic [2:0] M_WLEFT = 3'd4;
  localparam logic [2:0] M_WRGHT = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic grant_id;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack0_cnt = 0;
  int   ack1_cnt = 0;

  logic [7:0] mem [65536] = '{default: 8'h00};

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MODE_W(3)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MODE_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Memory: writes commit on the access edge, read data appears one cycle later
  always @(posedge clk) begin
    logic [15:0] a;
    logic [15:0] base;
    int          k;
    a    = bus.mem_address[15:0];
    base = {a[15:2], 2'b00};
    k    = int'(a[1:0]);
    case (bus.mem_writeMode)
      M_WORD:  for (int i = 0; i < 4; i++) mem[base + i] <= bus.mem_data[8*i +: 8];
      M_HALF:  for (int i = 0; i < 2; i++) mem[a + i] <= bus.mem_data[8*i +: 8];
      M_BYTE:  mem[a] <= bus.mem_data[7:0];
      M_WLEFT: for (int i = 0; i < 4; i++) if (i <= k) mem[base + i] <= bus.mem_data[8*(3-k+i) +: 8];
      M_WRGHT: for (int i = 0; i < 4; i++) if (i >= k) mem[base + i] <= bus.mem_data[8*(i-k) +: 8];
      default: ;
    endcase
    case (bus.mem_readMode)
      M_HALF: bus.mem_dataOutput <= bus.mem_unsignedLoad ? {16'h0, mem[a+1], mem[a]}
                                    : {{16{mem[a+1][7]}}, mem[a+1], mem[a]};
      M_BYTE: bus.mem_dataOutput <= bus.mem_unsignedLoad ? {24'h0, mem[a]}
                                    : {{24{mem[a][7]}}, mem[a]};
      M_NONE: ;
      default: bus.mem_dataOutput <= {mem[base+3], mem[base+2], mem[base+1], mem[base]};
    endcase
  end

  always @(negedge clk) begin
    if (bus.ack0) ack0_cnt++;
    if (bus.ack1) ack1_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] wm, input logic [2:0] rm, input logic u, input logic l);
    if (id == 0) begin
      bus.addr0 = a; bus.wdata0 = d; bus.wmode0 = wm; bus.rmode0 = rm;
      bus.unsigned0 = u; bus.lock0 = l; bus.req0 = 1'b1;
    end else begin
      bus.addr1 = a; bus.wdata1 = d; bus.wmode1 = wm; bus.rmode1 = rm;
      bus.unsigned1 = u; bus.lock1 = l; bus.req1 = 1'b1;
    end
  endtask

  task automatic wait_any_ack();
    int n;
    n = 0;
    while (!(bus.ack0 || bus.ack1) && n < 12) begin
      tick();
      n++;
    end
    check_value("ack_wait", {31'd0, bus.ack0 | bus.ack1}, 32'd1);
  endtask

  // Single transaction from IDLE; leaves the arbiter back in IDLE.
  task automatic transact(input int id, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] wm, input logic [2:0] rm, input logic u);
    int lat;
    set_req(id, a, d, wm, rm, u, 1'b0);
    lat = 0;
    while (!((id == 0) ? bus.ack0 : bus.ack1) && lat < 10) begin
      tick();
      lat++;
    end
    check_value($sformatf("latency_req%0d", id), lat, 32'd3);
    check_value($sformatf("grant_req%0d", id), {31'd0, grant_id}, id);
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_seq [4];
    int   a0_before;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.wmode0 = M_NONE;
    bus.rmode0 = M_NONE; bus.unsigned0 = 1'b0; bus.lock0 = 1'b0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.wmode1 = M_NONE;
    bus.rmode1 = M_NONE; bus.unsigned1 = 1'b0; bus.lock1 = 1'b0;

    #2;
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_grant", {31'd0, grant_id}, 32'd0);
    check_value("rst_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check_value("rst_rdata0", bus.rdata0, 32'd0);
    check_value("rst_rdata1", bus.rdata1, 32'd0);
    check_value("rst_modes", {26'd0, bus.mem_writeMode, bus.mem_readMode}, 32'd0);
    check_value("rst_addr", bus.mem_address, 32'd0);
    check_value("rst_data", bus.mem_data, 32'd0);
    check_value("rst_unsigned", {31'd0, bus.mem_unsignedLoad}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset during ACCESS of a WORD write must abort it
    set_req(0, 32'd65532, 32'h22345678, M_WORD, M_NONE, 1'b0, 1'b0);
    tick();
    check_value("abort_wmode_access", {29'd0, bus.mem_writeMode}, {29'd0, M_WORD});
    rst = 1'b1;
    #1;
    check_value("abort_wmode_async", {29'd0, bus.mem_writeMode}, {29'd0, M_NONE});
    check_value("abort_busy", {31'd0, busy}, 32'd0);
    bus.req0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check_value("abort_no_ack", ack0_cnt, 32'd0);
    transact(0, 32'd65532, 32'd0, M_NONE, M_WORD, 1'b0);
    check_value("abort_reread", bus.rdata0, 32'h00000000);

    // Requester 0 write then read back
    transact(0, 32'd65532, 32'h22345678, M_WORD, M_NONE, 1'b0);
    transact(0, 32'd65532, 32'd0, M_NONE, M_WORD, 1'b0);
    check_value("r0_readback", bus.rdata0, 32'h22345678);
    check_value("r0_no_ack1", ack1_cnt, 32'd0);

    // Requester 1 byte store/loads, signed and unsigned
    a0_before = ack0_cnt;
    transact(1, 32'd65531, 32'h000000A1, M_BYTE, M_NONE, 1'b0);
    transact(1, 32'd65531, 32'd0, M_NONE, M_BYTE, 1'b0);
    check_value("byte_signed", bus.rdata1, 32'hFFFFFFA1);
    transact(1, 32'd65531, 32'd0, M_NONE, M_BYTE, 1'b1);
    check_value("byte_unsigned", bus.rdata1, 32'h000000A1);
    check_value("byte_rdata0_kept", bus.rdata0, 32'h22345678);
    check_value("byte_no_ack0", ack0_cnt, a0_before);

    // Both requesters held high together
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
`else
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0;
`endif
    set_req(0, 32'd0, 32'd0, M_NONE, M_WORD, 1'b0, 1'b0);
    set_req(1, 32'd4, 32'd0, M_NONE, M_WORD, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_any_ack();
      check_value($sformatf("tie_grant%0d", k), {31'd0, grant_id}, {31'd0, exp_seq[k]});
      check_value($sformatf("tie_ack1_%0d", k), {31'd0, bus.ack1}, {31'd0, exp_seq[k]});
      if (k == 3) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        bus.req1 = 1'b0;
`endif
        bus.req0 = 1'b0;
      end
      tick();
    end
`ifndef MEM_ARB_ROUND_ROBIN_EN
    wait_any_ack();
    check_value("tie_after_drop", {31'd0, grant_id}, 32'd1);
    bus.req1 = 1'b0;
    tick();
`endif

    // Locked read-modify-write by requester 0 with requester 1 pending
    set_req(1, 32'd65528, 32'd0, M_NONE, M_WORD, 1'b0, 1'b0);
    set_req(0, 32'd65528, 32'd0, M_NONE, M_HALF, 1'b0, 1'b1);
    wait_any_ack();
    check_value("lock_grant_rd", {31'd0, grant_id}, 32'd0);
    check_value("lock_half_rd", bus.rdata0, 32'h00000000);
    set_req(0, 32'd65528, 32'h0000ABCD, M_HALF, M_NONE, 1'b0, 1'b0);
    tick();
    wait_any_ack();
    check_value("lock_grant_wr", {31'd0, grant_id}, 32'd0);
    bus.req0 = 1'b0;
    tick();
    wait_any_ack();
    check_value("lock_grant_r1", {31'd0, grant_id}, 32'd1);
    check_value("lock_word_rd", bus.rdata1, 32'hA100ABCD);
    bus.req1 = 1'b0;
    tick();

    // WORDLEFT store into a cleared word
    transact(1, 32'd65528, 32'h00000000, M_WORD, M_NONE, 1'b0);
    transact(1, 32'd65529, 32'h12345678, M_WLEFT, M_NONE, 1'b0);
    transact(1, 32'd65528, 32'd0, M_NONE, M_WORD, 1'b0);
    check_value("wordleft_rd", bus.rdata1, 32'h00001234);
    check_value("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
